axis_uart_tx_arbiter: RTL and testbench

- Shares one AXI-Stream UART transmitter (8-bit byte stream) between N_SRC requesters.
- Grants are round-robin and packet-locked: a source keeps the grant from the first byte until its tlast beat.
- Optionally prefixes each packet with a header byte carrying the source ID, so the far end can demultiplex.
- Sits between software or hardware byte producers and the UART TX datapath input.

---
 rtl/axis_uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one AXI-Stream byte
// transmitter between N_SRC producers. Each packet can optionally be
// preceded by a header byte carrying the source ID, with the MSB as a marker.
module axis_uart_tx_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int HEADER_EN  = 1,
  parameter int ID_WIDTH   = $clog2(N_SRC)
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [N_SRC-1:0]            s_axis_tvalid_i,
  input  logic [N_SRC-1:0]            s_axis_tlast_i,
  output logic [N_SRC-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i,
  output logic [N_SRC-1:0]            grant_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                state;
  logic [N_SRC-1:0]      grant;
  logic [ID_WIDTH-1:0]   gidx;
  logic [ID_WIDTH-1:0]   last;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] hdr_byte;

  // Round-robin search: first requester after the most recent owner wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = ID_WIDTH'((int'(last) + i) % N_SRC);
      if (!win_found && s_axis_tvalid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pass-through selection of the granted source using the one-hot grant.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant[k]) begin
        sel_data  = s_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid_i[k];
        sel_last  = s_axis_tlast_i[k];
      end
    end
  end

  // Header byte: owner index in the low bits, MSB flags it as a header.
  always_comb begin
    hdr_byte                 = '0;
    hdr_byte[ID_WIDTH-1:0]   = gidx;
    hdr_byte[DATA_WIDTH-1]   = 1'b1;
  end

  // Output decode from the registered state; DATA is a straight pass-through.
  always_comb begin
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    s_axis_tready_o = '0;
    case (state)
      HDR: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = hdr_byte;
      end
      DATA: begin
        m_axis_tvalid_o = sel_valid;
        m_axis_tdata_o  = sel_data;
        s_axis_tready_o = grant & {N_SRC{m_axis_tready_i}};
      end
      default: ;
    endcase
  end

  // Arbitration FSM: one IDLE cycle per grant, lock until the tlast beat.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= ID_WIDTH'(N_SRC - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= N_SRC'(1) << win_idx;
            gidx  <= win_idx;
            state <= (HEADER_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (m_axis_tready_i) state <= DATA;
        end
        DATA: begin
          if (sel_valid && m_axis_tready_i && sel_last) begin
            last  <= gidx;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_o = grant;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Self-checking bench for axis_uart_tx_arbiter: per-source beat queues drive
// the inputs, and an output scoreboard holds the expected byte stream.
module tb_axis_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk   = 1'b0;
  logic arstn = 1'b1;

  // Header-enabled instance
  logic [N*DW-1:0] s_tdata  = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tlast  = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [N-1:0]    grant;
  logic            busy;

  // Header-disabled instance
  logic [N*DW-1:0] t_tdata  = '0;
  logic [N-1:0]    t_tvalid = '0;
  logic [N-1:0]    t_tlast  = '0;
  logic [N-1:0]    t_tready;
  logic [DW-1:0]   t_mdata;
  logic            t_mvalid;
  logic            t_mready = 1'b1;
  logic [N-1:0]    t_grant;
  logic            t_busy;

  int checks  = 0;
  int errors  = 0;
  int in_cnt  = 0;
  int out_cnt = 0;
  bit rand_rdy = 1'b0;

  beat_t      sq [N][$];
  logic [7:0] exp_q [$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] exp_b;

  axis_uart_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .HEADER_EN(1)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .grant_o(grant), .busy_o(busy)
  );

  axis_uart_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .HEADER_EN(0)) dut_nohdr (
    .clk_i(clk), .arstn_i(arstn),
    .s_axis_tdata_i(t_tdata), .s_axis_tvalid_i(t_tvalid), .s_axis_tlast_i(t_tlast),
    .s_axis_tready_o(t_tready),
    .m_axis_tdata_o(t_mdata), .m_axis_tvalid_o(t_mvalid), .m_axis_tready_i(t_mready),
    .grant_o(t_grant), .busy_o(t_busy)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard pop on each handshake, hold check on stalls.
  always @(negedge clk) begin
    if (!arstn) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", m_tvalid, m_tdata, prev_data);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        checks++;
        out_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h, required no output", m_tdata);
        end else begin
          exp_b = exp_q.pop_front();
          if (m_tdata !== exp_b) begin
            errors++;
            $display("FAIL out_byte: got %h, required %h", m_tdata, exp_b);
          end
        end
      end
      prev_valid = m_tvalid;
      prev_ready = m_tready;
      prev_data  = m_tdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0);
    for (int k = 0; k < N; k++) if (sq[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (sq[k].size() > 0) begin
        s_tvalid[k]          = 1'b1;
        s_tdata[k*DW +: DW]  = sq[k][0].d;
        s_tlast[k]           = sq[k][0].l;
      end else begin
        s_tvalid[k]          = 1'b0;
        s_tdata[k*DW +: DW]  = '0;
        s_tlast[k]           = 1'b0;
      end
    end
  endtask

  // Queue a packet on a source and append header + bytes to the scoreboard.
  task automatic enqueue(input int src, input int n, input logic [7:0] base, input logic [7:0] step);
    beat_t      b;
    logic [7:0] v;
    exp_q.push_back(8'h80 | 8'(src));
    v = base;
    for (int i = 0; i < n; i++) begin
      b.d = v;
      b.l = (i == n - 1);
      sq[src].push_back(b);
      exp_q.push_back(v);
      v = v + step;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] hs;
    beat_t        tmp;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && sq[k].size() > 0) begin
        tmp = sq[k].pop_front();
        in_cnt++;
      end
    end
    drive();
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while ((pending() || busy) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still pending after %0d cycles, required drained", name, n);
    end
  endtask

  task automatic apply_reset();
    arstn = 1'b0;
    for (int k = 0; k < N; k++) sq[k].delete();
    exp_q.delete();
    drive();
    t_tvalid = '0;
    t_tlast  = '0;
    t_tdata  = '0;
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
  endtask

  task automatic test_reset();
    s_tvalid = '1;
    #2 arstn = 1'b0;
    #2;
    checks += 4;
    if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b, required 0000", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %b, required 0", m_tvalid); end
    if (s_tready !== '0) begin errors++; $display("FAIL rst_sready: got %b, required 0000", s_tready); end
    apply_reset();
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    apply_reset();
    enqueue(1, 3, 8'h11, 8'h11);
    drive();
    for (int i = 0; i < 5; i++) begin
      cycle();
      eg = (i < 4) ? 4'b0010 : 4'b0000;
      checks += 2;
      if (grant !== eg) begin errors++; $display("FAIL single_grant[%0d]: got %b, required %b", i, grant, eg); end
      if (busy !== (i < 4)) begin errors++; $display("FAIL single_busy[%0d]: got %b, required %b", i, busy, (i < 4)); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_left: got %0d bytes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_all_four();
    apply_reset();
    for (int k = 0; k < N; k++) enqueue(k, 2, 8'(16 * k + 1), 8'h01);
    drive();
    run_until_done("all4", 200);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL all4_end: grant=%b busy=%b, required 0000 0", grant, busy);
    end
  endtask

  task automatic test_rr_alternate();
    apply_reset();
    enqueue(0, 2, 8'h41, 8'h01);
    enqueue(3, 2, 8'h61, 8'h01);
    enqueue(0, 2, 8'h43, 8'h01);
    enqueue(3, 2, 8'h63, 8'h01);
    enqueue(0, 2, 8'h45, 8'h01);
    drive();
    run_until_done("rr", 200);
  endtask

  task automatic test_random_ready();
    int in0, out0, n;
    logic [N-1:0] exp_rdy;
    apply_reset();
    in0  = in_cnt;
    out0 = out_cnt;
    enqueue(1, 3, 8'h11, 8'h01);
    enqueue(2, 5, 8'h21, 8'h01);
    drive();
    rand_rdy = 1'b1;
    n = 0;
    while ((pending() || busy) && n < 400) begin
      cycle();
      #1;
      if (busy && !(m_tvalid && m_tdata[7])) begin
        exp_rdy = grant & {N{m_tready}};
        checks++;
        if (s_tready !== exp_rdy) begin
          errors++; $display("FAIL mirror: s_tready=%b, required %b", s_tready, exp_rdy);
        end
      end
      n++;
    end
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    checks += 2;
    if (n >= 400) begin errors++; $display("FAIL rand_timeout: got %0d cycles, required drained", n); end
    if ((out_cnt - out0) != (in_cnt - in0) + 2) begin
      errors++; $display("FAIL rand_count: out=%0d in=%0d, required out=in+2", out_cnt - out0, in_cnt - in0);
    end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    apply_reset();
    enqueue(2, 4, 8'h31, 8'h01);
    drive();
    repeat (3) cycle();
    checks++;
    if (exp_q.size() != 3) begin errors++; $display("FAIL mid_progress: outstanding=%0d, required 3", exp_q.size()); end
    arstn = 1'b0;
    #1;
    checks += 4;
    if (grant !== '0) begin errors++; $display("FAIL mid_grant: got %b, required 0000", grant); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_mvalid: got %b, required 0", m_tvalid); end
    if (s_tready !== '0) begin errors++; $display("FAIL mid_sready: got %b, required 0000", s_tready); end
    exp_q.delete();
    exp_q.push_back(8'h80); exp_q.push_back(8'h05);
    exp_q.push_back(8'h82); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    b.d = 8'h05;
    b.l = 1'b1;
    sq[0].push_back(b);
    drive();
    @(posedge clk);
    #1 arstn = 1'b1;
    run_until_done("mid", 200);
  endtask

  task automatic test_no_header();
    apply_reset();
    t_tvalid[3]          = 1'b1;
    t_tlast[3]           = 1'b1;
    t_tdata[3*DW +: DW]  = 8'hA5;
    #1;
    checks += 2;
    if (t_mvalid !== 1'b0) begin errors++; $display("FAIL nh_arb_valid: got %b, required 0", t_mvalid); end
    if (t_tready !== '0) begin errors++; $display("FAIL nh_arb_ready: got %b, required 0000", t_tready); end
    @(posedge clk);
    #1;
    checks += 4;
    if (t_mvalid !== 1'b1) begin errors++; $display("FAIL nh_valid: got %b, required 1", t_mvalid); end
    if (t_mdata !== 8'hA5) begin errors++; $display("FAIL nh_data: got %h, required a5", t_mdata); end
    if (t_grant !== 4'b1000) begin errors++; $display("FAIL nh_grant: got %b, required 1000", t_grant); end
    if (t_tready !== 4'b1000) begin errors++; $display("FAIL nh_ready: got %b, required 1000", t_tready); end
    @(posedge clk);
    #1;
    t_tvalid = '0;
    t_tlast  = '0;
    t_tdata  = '0;
    #1;
    checks += 3;
    if (t_busy !== 1'b0) begin errors++; $display("FAIL nh_busy_end: got %b, required 0", t_busy); end
    if (t_grant !== '0) begin errors++; $display("FAIL nh_grant_end: got %b, required 0000", t_grant); end
    if (t_mvalid !== 1'b0) begin errors++; $display("FAIL nh_valid_end: got %b, required 0", t_mvalid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_alternate();
    test_random_ready();
    test_reset_mid();
    test_no_header();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
